vga_sync_gen: RTL and testbench

//   Raster timing generator for the VGA display path. Divides clk into a pixel tick,

---
 rtl/vga_sync_gen.sv | 133 +++++++++++++
 tb/tb_vga_sync_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel tick, pix_x/pix_y scan, registered hsync/vsync/video_on.
// Define VGA_SYNC_RGB_PIPE_EN to add the registered rgb path and the one-pixel sync delay.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef VGA_SYNC_RGB_PIPE_EN
  input  logic [2:0] rgb_in,
  output logic [2:0] rgb,
`endif
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       ACT      = 1'(SYNC_POL);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_sync_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end
  endgenerate

  logic [DW-1:0] div_q, div_d;
  logic          tick_q;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          von_q, von_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    x_d   = x_q;
    y_d   = y_q;
    if (tick_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // decode the position the counters are about to hold
    von_d = (x_d < H_VIS) && (y_d < V_VIS);
    hs_d  = (x_d >= HS_FIRST && x_d <= HS_LAST) ? ACT : ~ACT;
    vs_d  = (y_d >= VS_FIRST && y_d <= VS_LAST) ? ACT : ~ACT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      hs_q   <= ~ACT;
      vs_q   <= ~ACT;
      von_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_q == DIV_LAST);
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
    end
  end

  assign p_tick      = tick_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = tick_q && (x_q == H_LAST) && (y_q == V_LAST);

`ifdef VGA_SYNC_RGB_PIPE_EN
  logic       hs2_q;
  logic       vs2_q;
  logic       von2_q;
  logic [2:0] rgb_q;

  // one pixel of delay to line up with the overlay's synchronous font ROM
  always_ff @(posedge clk) begin
    if (reset) begin
      hs2_q  <= ~ACT;
      vs2_q  <= ~ACT;
      von2_q <= 1'b0;
      rgb_q  <= 3'b000;
    end else if (tick_q) begin
      hs2_q  <= hs_q;
      vs2_q  <= vs_q;
      von2_q <= von_q;
      rgb_q  <= von_q ? rgb_in : 3'b000;
    end
  end

  assign hsync    = hs2_q;
  assign vsync    = vs2_q;
  assign video_on = von2_q;
  assign rgb      = rgb_q;
`else
  assign hsync    = hs_q;
  assign vsync    = vs_q;
  assign video_on = von_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: arithmetic raster model checked every cycle,
// plus literal checks on reset, line length, sync placement and frame counts.
module tb_vga_sync_gen;

  logic clk;
  logic reset;

  logic [9:0] xa, ya, xb, yb;
  logic pta, voa, hsa, vsa, fsa;
  logic ptb, vob, hsb, vsb, fsb;

  int n;
  int cmp;
  int mis;

`ifdef VGA_SYNC_RGB_PIPE_EN
  logic [2:0] rgb_a, rgb_b;
`endif

  vga_sync_gen dut_a (
    .clk(clk), .reset(reset),
`ifdef VGA_SYNC_RGB_PIPE_EN
    .rgb_in(3'b010), .rgb(rgb_a),
`endif
    .p_tick(pta), .pix_x(xa), .pix_y(ya),
    .video_on(voa), .hsync(hsa), .vsync(vsa),
    .frame_start(fsa)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .V_DISPLAY(10), .V_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .reset(reset),
`ifdef VGA_SYNC_RGB_PIPE_EN
    .rgb_in(3'b010), .rgb(rgb_b),
`endif
    .p_tick(ptb), .pix_x(xb), .pix_y(yb),
    .video_on(vob), .hsync(hsb), .vsync(vsb),
    .frame_start(fsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clocks elapsed since the last reset edge (-1 before any reset)
  initial n = -1;
  always @(posedge clk) begin
    if (reset) n <= 0;
    else if (n >= 0) n <= n + 1;
  end

  // outputs after edge k of the run: pixel index = ticks seen so far
  function automatic logic [24:0] model(
    input int k, input int d,
    input int hd, input int hf, input int hs, input int hb,
    input int vd, input int vf, input int vs, input int vb,
    input logic pol);
    int ht, vt, p, x, y;
    logic pt, vo, h, v, f;
    if (k <= 0) return {10'd0, 10'd0, 1'b0, 1'b0, ~pol, ~pol, 1'b0};
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    p  = ((k - 1) / d) % (ht * vt);
    x  = p % ht;
    y  = p / ht;
    pt = (k % d) == 0;
    vo = (x < hd) && (y < vd);
    h  = (x >= hd + hf && x < hd + hf + hs) ? pol : ~pol;
    v  = (y >= vd + vf && y < vd + vf + vs) ? pol : ~pol;
    f  = pt && (x == ht - 1) && (y == vt - 1);
    return {10'(x), 10'(y), pt, vo, h, v, f};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    cmp++;
    if (got !== want) begin
      mis++;
      $display("FAIL %s n=%0d got %h want %h", nm, n, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (n >= 0) begin
      chk("model_a", {7'd0, xa, ya, pta, voa, hsa, vsa, fsa},
          {7'd0, model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)});
      chk("model_b", {7'd0, xb, yb, ptb, vob, hsb, vsb, fsb},
          {7'd0, model(n, 1, 640, 16, 96, 48, 10, 2, 2, 3, 1'b1)});
    end
  endtask

  int t1, t2, tb1, tb2, hlow, hfirst, hbfirst, k, cnt, von, vsn;

  initial begin
    cmp = 0;
    mis = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    step();
    chk("rst_x_a", xa, 0);
    chk("rst_pt_a", pta, 0);
    chk("rst_vo_a", voa, 0);
    chk("rst_hs_a", hsa, 1);
    chk("rst_vs_a", vsa, 1);
    chk("rst_fs_a", fsa, 0);
    chk("rst_hs_b", hsb, 0);
    reset = 1'b0;

    step();
    chk("rel_vo_a", voa, 1);
    chk("rel_pt_a", pta, 0);
    chk("rel_hs_a", hsa, 1);
    chk("rel_pt_b", ptb, 1);
    step();
    chk("tick1_pt_a", pta, 1);
    chk("tick1_x_a", xa, 0);
    step();
    chk("tick2_x_a", xa, 1);
    chk("tick2_pt_a", pta, 0);

    t1 = -1; t2 = -1; tb1 = -1; tb2 = -1;
    hlow = 0; hfirst = -1; hbfirst = -1;
    for (int i = 0; i < 3300; i++) begin
      step();
      if (pta && xa == 0 && ya == 1 && t1 < 0) t1 = n;
      if (pta && xa == 0 && ya == 2 && t2 < 0) t2 = n;
      if (ptb && xb == 0 && yb == 1 && tb1 < 0) tb1 = n;
      if (ptb && xb == 0 && yb == 2 && tb2 < 0) tb2 = n;
      if (ya == 0 && !hsa) hlow++;
      if (!hsa && hfirst < 0) hfirst = int'(xa);
      if (hsb && hbfirst < 0) hbfirst = int'(xb);
    end
    chk("line_clks_a", t2 - t1, 1600);
    chk("hsync_low_clks_a", hlow, 192);
    chk("hsync_first_x_a", hfirst, 656);
    chk("line_clks_b", tb2 - tb1, 800);
    chk("hsync_first_x_b", hbfirst, 656);

    k = 0;
    while (!(xb == 10'd700 && yb == 10'd12) && k < 20000) begin
      step();
      k++;
    end
    chk("mid_pos_b", {12'd0, xb, yb}, {12'd0, 10'd700, 10'd12});
    chk("mid_hs_b", hsb, 1);
    chk("mid_vs_b", vsb, 1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_x_b", xb, 0);
    chk("midrst_y_b", yb, 0);
    chk("midrst_hs_b", hsb, 0);
    chk("midrst_vs_b", vsb, 0);
    chk("midrst_hs_a", hsa, 1);
    chk("midrst_vs_a", vsa, 1);

    k = 0;
    while (!fsb && k < 20000) begin
      step();
      k++;
    end
    chk("fs_seen_b", fsb, 1);

    cnt = 0; von = 0; vsn = 0;
    do begin
      step();
      cnt++;
      if (ptb && vob) von++;
      if (ptb && vsb) vsn++;
    end while (!fsb && cnt < 20000);
    chk("frame_clks_b", cnt, 13600);
    chk("video_ticks_b", von, 6400);
    chk("vsync_ticks_b", vsn, 1600);

    repeat (10) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
